// File: rtl/mul_sequencer_if.sv
// Request/response and ALU-bus bundle for the shift-and-add MUL sequencer.
interface mul_sequencer_if;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned CTRL_W = 4;

   // request / response side
   logic              start;
   logic [DATA_W-1:0] opA;
   logic [DATA_W-1:0] opB;
   logic              ready;
   logic              done;
   logic [DATA_W-1:0] product;

   // shared ALU side
   logic [DATA_W-1:0] aluA;
   logic [DATA_W-1:0] aluB;
   logic [CTRL_W-1:0] aluCtrl;
   logic [DATA_W-1:0] aluW;
   logic              aluZero;

   // requester issuing multiplies
   modport master (
      output start, opA, opB,
      input  ready, done, product
   );

   // the sequencer itself
   modport slave (
      input  start, opA, opB, aluW, aluZero,
      output ready, done, product, aluA, aluB, aluCtrl
   );

   // the shared ALU
   modport alu (
      input  aluA, aluB, aluCtrl,
      output aluW, aluZero
   );
endinterface

// File: rtl/mul_sequencer.sv
// Multi-cycle 64-bit MUL controller that iterates shift-and-add on the shared ALU.
// A PASSB of the remaining multiplier doubles as the loop test: a zero flag ends it.
module mul_sequencer (
   input logic            CLK,
   input logic            Reset,
   mul_sequencer_if.slave bus
);
   localparam int unsigned DATA_W = 64;
   localparam int unsigned CTRL_W = 4;
   localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0010;
   localparam logic [CTRL_W-1:0] ALU_PASSB = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_STEP  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] p_q, p_d;
   logic [DATA_W-1:0] m_q, m_d;
   logic [DATA_W-1:0] q_q, q_d;
   logic [DATA_W-1:0] product_q, product_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;

   // State, datapath registers and registered outputs; synchronous reset wins over start
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         p_q        <= '0;
         m_q        <= '0;
         q_q        <= '0;
         product_q  <= '0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_ctrl_q <= ALU_PASSB;
      end else begin
         state_q    <= state_d;
         p_q        <= p_d;
         m_q        <= m_d;
         q_q        <= q_d;
         product_q  <= product_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_ctrl_q <= alu_ctrl_d;
      end
   end

   // Next state and datapath, then the outputs the next state will present
   always_comb begin
      state_d    = state_q;
      p_d        = p_q;
      m_d        = m_q;
      q_d        = q_q;
      product_d  = product_q;
      ready_d    = 1'b0;
      done_d     = 1'b0;
      alu_a_d    = '0;
      alu_b_d    = '0;
      alu_ctrl_d = ALU_PASSB;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               m_d     = bus.opA;
               q_d     = bus.opB;
               p_d     = '0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (bus.aluZero) begin
               product_d = p_q;
               state_d   = S_DONE;
            end else begin
               state_d   = S_STEP;
            end
         end
         S_STEP: begin
            p_d     = bus.aluW;
            m_d     = DATA_W'(m_q << 1);
            q_d     = DATA_W'(q_q >> 1);
            state_d = S_CHECK;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // ALU drive is derived from next-cycle state only, so start/opA/opB never reach it directly
      case (state_d)
         S_IDLE: begin
            ready_d = 1'b1;
         end
         S_CHECK: begin
            alu_a_d    = p_d;
            alu_b_d    = q_d;
            alu_ctrl_d = ALU_PASSB;
         end
         S_STEP: begin
            alu_a_d    = p_d;
            alu_b_d    = q_d[0] ? m_d : '0;
            alu_ctrl_d = ALU_ADD;
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            ready_d = 1'b0;
         end
      endcase
   end

   assign bus.ready   = ready_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
   assign bus.aluA    = alu_a_q;
   assign bus.aluB    = alu_b_q;
   assign bus.aluCtrl = alu_ctrl_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: behavioural ALU plus an arithmetic reference for product, latency and bus trace.
module tb_mul_sequencer;
   localparam logic [3:0] C_ADD   = 4'b0010;
   localparam logic [3:0] C_PASSB = 4'b0111;
   localparam int unsigned LOGN   = 160;

   logic CLK;
   logic Reset;
   logic [63:0] alu_w;

   int vectors;
   int miscompares;

   logic [3:0]  ctrl_log [0:LOGN-1];
   logic [63:0] a_log    [0:LOGN-1];
   logic [63:0] b_log    [0:LOGN-1];
   logic [63:0] prod_log [0:LOGN-1];
   logic        rdy_log  [0:LOGN-1];
   logic        done_log [0:LOGN-1];
   int          done_cyc;
   int          done_cnt;

   mul_sequencer_if ifc ();

   mul_sequencer dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (ifc.slave)
   );

   // behavioural 64-bit ALU
   always_comb begin
      case (ifc.aluCtrl)
         4'b0000: alu_w = ifc.aluA & ifc.aluB;
         4'b0001: alu_w = ifc.aluA | ifc.aluB;
         4'b0010: alu_w = ifc.aluA + ifc.aluB;
         4'b0110: alu_w = ifc.aluA - ifc.aluB;
         4'b0111: alu_w = ifc.aluB;
         default: alu_w = '0;
      endcase
   end
   assign ifc.aluW    = alu_w;
   assign ifc.aluZero = (alu_w == 64'd0);

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // number of significant bits of the multiplier
   function automatic int ref_k(input logic [63:0] b);
      int k;
      k = 0;
      for (int i = 0; i < 64; i++)
         if (b[i]) k = i + 1;
      return k;
   endfunction

   task automatic do_reset();
      Reset = 1'b1;
      ifc.start = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      Reset = 1'b0;
   endtask

   // issue one request and log ncyc cycles after the accepting edge
   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int ncyc,
                         input bit hold, input logic [63:0] ja, input logic [63:0] jb);
      ifc.start = 1'b1;
      ifc.opA   = a;
      ifc.opB   = b;
      done_cyc  = 0;
      done_cnt  = 0;
      for (int c = 0; c < int'(LOGN); c++) begin
         ctrl_log[c] = 4'hx; a_log[c] = 'x; b_log[c] = 'x;
         prod_log[c] = 'x; rdy_log[c] = 1'bx; done_log[c] = 1'bx;
      end
      @(posedge CLK);
      #1;
      if (hold) begin
         ifc.opA = ja;
         ifc.opB = jb;
      end else begin
         ifc.start = 1'b0;
      end
      for (int c = 1; c <= ncyc; c++) begin
         ctrl_log[c] = ifc.aluCtrl;
         a_log[c]    = ifc.aluA;
         b_log[c]    = ifc.aluB;
         prod_log[c] = ifc.product;
         rdy_log[c]  = ifc.ready;
         done_log[c] = ifc.done;
         if (ifc.done === 1'b1) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
            ifc.start = 1'b0;
         end
         @(posedge CLK);
         #1;
      end
      ifc.start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (ifc.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", ifc.ready); end
      vectors++; if (ifc.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", ifc.done); end
      vectors++; if (ifc.product !== 64'd0) begin miscompares++; $display("FAIL reset_product got %h exp 0", ifc.product); end
      vectors++; if (ifc.aluA !== 64'd0) begin miscompares++; $display("FAIL reset_aluA got %h exp 0", ifc.aluA); end
      vectors++; if (ifc.aluB !== 64'd0) begin miscompares++; $display("FAIL reset_aluB got %h exp 0", ifc.aluB); end
      vectors++; if (ifc.aluCtrl !== C_PASSB) begin miscompares++; $display("FAIL reset_aluCtrl got %b exp %b", ifc.aluCtrl, C_PASSB); end
   endtask

   task automatic test_6x7();
      logic [3:0] ec;
      do_reset();
      run_op(64'd6, 64'd7, 11, 1'b0, 64'd0, 64'd0);
      vectors++; if (done_cyc !== 8) begin miscompares++; $display("FAIL m6x7_done_cycle got %0d exp 8", done_cyc); end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL m6x7_done_count got %0d exp 1", done_cnt); end
      vectors++; if (prod_log[8] !== 64'd42) begin miscompares++; $display("FAIL m6x7_product got %0d exp 42", prod_log[8]); end
      vectors++; if (rdy_log[9] !== 1'b1) begin miscompares++; $display("FAIL m6x7_ready_after got %b exp 1", rdy_log[9]); end
      vectors++; if (prod_log[11] !== 64'd42) begin miscompares++; $display("FAIL m6x7_product_held got %0d exp 42", prod_log[11]); end
      for (int c = 1; c <= 7; c++) begin
         ec = (c % 2 == 1) ? C_PASSB : C_ADD;
         vectors++;
         if (ctrl_log[c] !== ec) begin
            miscompares++; $display("FAIL m6x7_ctrl cycle %0d got %b exp %b", c, ctrl_log[c], ec);
         end
      end
   endtask

   task automatic test_zero_multiplier();
      do_reset();
      run_op(64'h1234, 64'd0, 4, 1'b0, 64'd0, 64'd0);
      vectors++; if (ctrl_log[1] !== C_PASSB || b_log[1] !== 64'd0 || rdy_log[1] !== 1'b0) begin
         miscompares++; $display("FAIL zero_check_c1 got ctrl %b aluB %h ready %b exp 0111/0/0", ctrl_log[1], b_log[1], rdy_log[1]); end
      vectors++; if (done_cyc !== 2) begin miscompares++; $display("FAIL zero_done_cycle got %0d exp 2", done_cyc); end
      vectors++; if (prod_log[2] !== 64'd0) begin miscompares++; $display("FAIL zero_product got %h exp 0", prod_log[2]); end
      vectors++; if (rdy_log[3] !== 1'b1) begin miscompares++; $display("FAIL zero_ready_c3 got %b exp 1", rdy_log[3]); end
   endtask

   task automatic test_signed_wrap();
      do_reset();
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 8, 1'b0, 64'd0, 64'd0);
      vectors++; if (done_cyc !== 6) begin miscompares++; $display("FAIL wrap_done_cycle got %0d exp 6", done_cyc); end
      vectors++; if (prod_log[6] !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         miscompares++; $display("FAIL wrap_product got %h exp fffffffffffffffd", prod_log[6]); end
   endtask

   task automatic test_worst_case();
      do_reset();
      run_op(64'd2, 64'h8000_0000_0000_0000, 132, 1'b0, 64'd0, 64'd0);
      vectors++; if (done_cyc !== 130) begin miscompares++; $display("FAIL worst_done_cycle got %0d exp 130", done_cyc); end
      vectors++; if (prod_log[130] !== 64'd0) begin miscompares++; $display("FAIL worst_product got %h exp 0", prod_log[130]); end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL worst_done_count got %0d exp 1", done_cnt); end
      // steps 1..63 see a zero multiplier LSB
      for (int c = 2; c <= 126; c += 2) begin
         vectors++;
         if (ctrl_log[c] !== C_ADD || b_log[c] !== 64'd0) begin
            miscompares++; $display("FAIL worst_step cycle %0d got ctrl %b aluB %h exp 0010/0", c, ctrl_log[c], b_log[c]);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [63:0] ja, jb;
      do_reset();
      ja = {$urandom, $urandom} | 64'd1;
      jb = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      run_op(64'd5, 64'd5, 10, 1'b1, ja, jb);
      vectors++; if (done_cyc !== 8) begin miscompares++; $display("FAIL busy_done_cycle got %0d exp 8", done_cyc); end
      vectors++; if (prod_log[8] !== 64'd25) begin miscompares++; $display("FAIL busy_product got %0d exp 25", prod_log[8]); end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL busy_done_count got %0d exp 1", done_cnt); end
      vectors++; if (rdy_log[9] !== 1'b1 || rdy_log[10] !== 1'b1) begin
         miscompares++; $display("FAIL busy_idle_after got %b%b exp 11", rdy_log[9], rdy_log[10]); end
   endtask

   task automatic test_abort();
      int dn;
      do_reset();
      run_op(64'd5, 64'd5, 9, 1'b0, 64'd0, 64'd0);
      vectors++; if (prod_log[9] !== 64'd25) begin miscompares++; $display("FAIL abort_first_product got %0d exp 25", prod_log[9]); end
      ifc.start = 1'b1; ifc.opA = 64'd5; ifc.opB = 64'd5;
      @(posedge CLK); #1;            // cycle 1
      ifc.start = 1'b0;
      @(posedge CLK); #1;            // cycle 2
      @(posedge CLK); #1;            // cycle 3
      Reset = 1'b1;
      ifc.start = 1'b1;              // reset must win over start
      @(posedge CLK); #1;            // cycle 4
      Reset = 1'b0;
      ifc.start = 1'b0;
      vectors++; if (ifc.ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got %b exp 1", ifc.ready); end
      vectors++; if (ifc.product !== 64'd0) begin miscompares++; $display("FAIL abort_product got %h exp 0", ifc.product); end
      vectors++; if (ifc.aluCtrl !== C_PASSB || ifc.aluA !== 64'd0) begin
         miscompares++; $display("FAIL abort_alu got ctrl %b aluA %h exp 0111/0", ifc.aluCtrl, ifc.aluA); end
      dn = 0;
      for (int c = 0; c < 12; c++) begin
         if (ifc.done !== 1'b0 || ifc.ready !== 1'b1) dn++;
         @(posedge CLK); #1;
      end
      vectors++; if (dn !== 0) begin miscompares++; $display("FAIL abort_no_done got %0d busy/done cycles exp 0", dn); end
   endtask

   task automatic test_back_to_back();
      int d1, d2, nd;
      logic [63:0] p1, p2;
      logic r7, r8;
      do_reset();
      ifc.start = 1'b1; ifc.opA = 64'd3; ifc.opB = 64'd2;
      @(posedge CLK); #1;
      ifc.opA = 64'd4; ifc.opB = 64'd4;
      d1 = 0; d2 = 0; nd = 0; p1 = 'x; p2 = 'x; r7 = 1'bx; r8 = 1'bx;
      for (int c = 1; c <= 18; c++) begin
         if (c == 7) r7 = ifc.ready;
         if (c == 8) begin r8 = ifc.ready; ifc.start = 1'b0; end
         if (ifc.done === 1'b1) begin
            nd++;
            if (d1 == 0) begin d1 = c; p1 = ifc.product; end
            else if (d2 == 0) begin d2 = c; p2 = ifc.product; end
         end
         @(posedge CLK); #1;
      end
      ifc.start = 1'b0;
      vectors++; if (d1 !== 6) begin miscompares++; $display("FAIL b2b_first_done got %0d exp 6", d1); end
      vectors++; if (p1 !== 64'd6) begin miscompares++; $display("FAIL b2b_first_product got %0d exp 6", p1); end
      vectors++; if (r7 !== 1'b1 || r8 !== 1'b0) begin
         miscompares++; $display("FAIL b2b_second_accept got ready c7 %b c8 %b exp 1/0", r7, r8); end
      vectors++; if (d2 !== 15) begin miscompares++; $display("FAIL b2b_second_done got %0d exp 15", d2); end
      vectors++; if (p2 !== 64'd16) begin miscompares++; $display("FAIL b2b_second_product got %0d exp 16", p2); end
      vectors++; if (nd !== 2) begin miscompares++; $display("FAIL b2b_done_count got %0d exp 2", nd); end
   endtask

   task automatic test_random();
      logic [63:0] a, b, mask, ea, eb, prod;
      int k;
      for (int n = 0; n < 16; n++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom} >> $urandom_range(0, 63);
         if (n == 3) b = 64'd0;
         k = ref_k(b);
         prod = a * b;
         do_reset();
         run_op(a, b, 2 * k + 4, 1'b0, 64'd0, 64'd0);
         vectors++; if (done_cyc !== 2 * k + 2) begin
            miscompares++; $display("FAIL rand_done_cycle run %0d got %0d exp %0d", n, done_cyc, 2 * k + 2); end
         vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL rand_done_count run %0d got %0d exp 1", n, done_cnt); end
         vectors++; if (prod_log[2 * k + 2] !== prod) begin
            miscompares++; $display("FAIL rand_product run %0d a %h b %h got %h exp %h", n, a, b, prod_log[2 * k + 2], prod); end
         vectors++; if (rdy_log[2 * k + 3] !== 1'b1) begin
            miscompares++; $display("FAIL rand_ready_after run %0d got %b exp 1", n, rdy_log[2 * k + 3]); end
         // bus trace from the arithmetic view: partial sum of the low j-1 multiplier bits
         for (int j = 1; j <= k + 1; j++) begin
            mask = (64'd1 << (j - 1)) - 64'd1;
            ea = a * (b & mask);
            eb = b >> (j - 1);
            vectors++;
            if (ctrl_log[2 * j - 1] !== C_PASSB || a_log[2 * j - 1] !== ea || b_log[2 * j - 1] !== eb) begin
               miscompares++;
               $display("FAIL rand_check run %0d cyc %0d got %b %h %h exp %b %h %h", n, 2 * j - 1,
                        ctrl_log[2 * j - 1], a_log[2 * j - 1], b_log[2 * j - 1], C_PASSB, ea, eb);
            end
            if (j <= k) begin
               eb = b[j - 1] ? (a << (j - 1)) : 64'd0;
               vectors++;
               if (ctrl_log[2 * j] !== C_ADD || a_log[2 * j] !== ea || b_log[2 * j] !== eb) begin
                  miscompares++;
                  $display("FAIL rand_step run %0d cyc %0d got %b %h %h exp %b %h %h", n, 2 * j,
                           ctrl_log[2 * j], a_log[2 * j], b_log[2 * j], C_ADD, ea, eb);
               end
            end
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      Reset       = 1'b1;
      ifc.start   = 1'b0;
      ifc.opA     = '0;
      ifc.opB     = '0;
      test_reset();
      test_6x7();
      test_zero_multiplier();
      test_signed_wrap();
      test_worst_case();
      test_busy_ignore();
      test_abort();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle 64-bit multiplier controller for the LEGv8 datapath. It implements MUL by driving the shared 64-bit ALU: it produces the ALU's operand buses and 4-bit control code each cycle, and consumes the ALU's result bus and zero flag. Iteration is shift-and-add. The ALU zero flag on a PASSB of the remaining multiplier terminates the loop early. The result is the low 64 bits of the product, which is correct for both signed and unsigned two's-complement operands.

## Interface
- No parameters. Data width is fixed at 64. ALU control codes used: ADD = 4'b0010, PASSB = 4'b0111.
- CLK  input  1  sole clock; all state changes on the rising edge
- Reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- opA  input  64  multiplicand; captured on the accepting edge
- opB  input  64  multiplier; captured on the accepting edge
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse in DONE
- product  output  64  last completed result; held until the next completion
- aluA  output  64  to ALU busA
- aluB  output  64  to ALU busB
- aluCtrl  output  4  to ALU ctrl
- aluW  input  64  from ALU busW
- aluZero  input  1  from ALU zero (1 when busW == 0)

## Operation
- Internal registers: state, P (accumulator, 64), M (shifted multiplicand, 64), Q (remaining multiplier, 64), product (64).
- IDLE
  - ready=1.
  - On start=1: M<=opA, Q<=opB, P<=0, go to CHECK.
  - With start=0: stay in IDLE.
- CHECK
  - Drives aluCtrl=PASSB, aluA=P, aluB=Q.
  - If aluZero=1: product<=P, go to DONE.
  - Otherwise go to STEP.
- STEP
  - Drives aluCtrl=ADD, aluA=P, aluB = Q[0] ? M : 0.
  - Updates P<=aluW, M<=M<<1 (MSB discarded), Q<=Q>>1 (logical shift), then go to CHECK.
- DONE
  - done=1.
  - Go to IDLE unconditionally.
- ALU outputs in IDLE and DONE: aluA=0, aluB=0, aluCtrl=PASSB.
- ALU outputs are functions of registered state only. There is no combinational path from start, opA or opB to the ALU outputs.
- Arithmetic is modulo 2^64. No overflow flag. High product bits are discarded.
- start in any state other than IDLE, including DONE, is ignored. Operands are not re-sampled while busy.
- Reset (any state, mid-operation included):
  - State goes to IDLE.
  - P, M, Q and product go to 0.
  - done=0 and ready=1 in the cycle after the reset edge.
  - An aborted operation never pulses done.
- Reset has priority over start on the same edge.

## Timing
- Define k = index of the highest set bit of opB, plus 1. k=0 when opB=0.
- Number the cycle right after the accepting edge as cycle 1.
  - Cycles 1..2k alternate CHECK and STEP.
  - Cycle 2k+1 is the final CHECK.
  - Cycle 2k+2 is DONE (done=1).
  - Cycle 2k+3 is IDLE (ready=1).
- Latency: minimum 2 cycles (opB=0), maximum 130 cycles (opB MSB set).
- product updates on the edge that enters DONE. It is therefore valid in the same cycle done=1, and it is stable afterwards.
- The earliest next accept is the edge ending cycle 2k+3. Back-to-back throughput is one operation per 2k+3 cycles.
- Reset values of outputs: ready=1, done=0, product=0, aluA=0, aluB=0, aluCtrl=4'b0111.

## Test plan
- Bench uses a real ALU instance connected to the ALU ports. Each case below is run after reset.
- 6×7: start with opA=6, opB=7.
  - Required: done=1 only in cycle 8, product=42.
  - Required: aluCtrl sequence PASSB, ADD ×3 alternating, ending with PASSB in cycle 7.
- Zero multiplier: opA=0x1234, opB=0.
  - Required: CHECK in cycle 1, done in cycle 2, product=0, ready=1 in cycle 3.
- Signed wrap: opA=0xFFFF_FFFF_FFFF_FFFF, opB=3.
  - Required: product=0xFFFF_FFFF_FFFF_FFFD, done in cycle 6.
- Worst case / overflow: opA=2, opB=0x8000_0000_0000_0000.
  - Required: done in cycle 130, product=0.
  - Required: in every STEP where Q[0]=0, aluB=0 and aluCtrl=0010.
- Busy/abort, opA=5, opB=5:
  - start held high with other operands during busy cycles: those operands are ignored, and the result is product=25 in cycle 8.
  - A repeat run with Reset=1 during cycle 3: ready=1 and product=0 in the next cycle, and no done pulse.
- Back-to-back: start held continuously with 3×2 and then 4×4.
  - Required: first done in cycle 6 with product=6.
  - Required: second accept on the edge ending cycle 7, its done 8 cycles later, product=16.
